// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
package alu_seq_pkg;

  localparam int unsigned OPW = 3;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_AND = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GOT_A = 3'd1,
    ST_GOT_B = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/alu_operand_sequencer_btn_pulse.sv
// btn_pulse: synchroniser chain plus rising-edge detector for one raw button.
// Produces a single-cycle pulse per press. After reset the detector stays
// disarmed until the synchronised level has been seen low, so a button held
// through reset release does not fire until it is released and pressed again.
module btn_pulse #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_prev;
  logic                   r_armed;
  logic                   w_level;
  logic                   w_fill_done;

  assign w_level     = r_sync[SYNC_STAGES-1];
  assign w_fill_done = r_fill[SYNC_STAGES-1];

  // Synchronise the raw level and track when the chain holds real samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Edge history and arming once a genuine released level has been observed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev <= w_level;
      if (w_fill_done && !w_level) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_pulse = r_armed & w_level & ~r_prev;

endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: steps operands a, b and mode/carry into an external
// ALU from switches, one button press per step, then captures the result.
// Optional feature: define ALU_SEQ_CHAIN_EN so a new operation started from
// DONE takes a from the previous result instead of the switches.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] sw,
  input  logic           btn_load,
  input  logic           btn_clear,
  input  logic [OPW-1:0] alu_result,
  input  logic           alu_c_out,
  output logic [OPW-1:0] a,
  output logic [OPW-1:0] b,
  output logic [1:0]     mode,
  output logic           c_in,
  output logic [OPW-1:0] res_q,
  output logic           cout_q,
  output logic           res_valid,
  output logic [2:0]     state_o
);

  logic           w_load_p;
  logic           w_clear_p;
  state_t         r_state;
  logic [OPW-1:0] r_a;
  logic [OPW-1:0] r_b;
  logic [1:0]     r_mode;
  logic           r_c_in;
  logic [OPW-1:0] r_res_q;
  logic           r_cout_q;
  logic           r_res_valid;

  btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_load_pulse (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_btn   (btn_load),
    .o_pulse (w_load_p)
  );

  btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_clear_pulse (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_btn   (btn_clear),
    .o_pulse (w_clear_p)
  );

  // Sequencer FSM; clear takes priority over load in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_mode      <= '0;
      r_c_in      <= 1'b0;
      r_res_q     <= '0;
      r_cout_q    <= 1'b0;
      r_res_valid <= 1'b0;
    end else if (w_clear_p) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_mode      <= '0;
      r_c_in      <= 1'b0;
      r_res_q     <= '0;
      r_cout_q    <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load_p) begin
            r_a     <= sw;
            r_state <= ST_GOT_A;
          end
        end
        ST_GOT_A: begin
          if (w_load_p) begin
            r_b     <= sw;
            r_state <= ST_GOT_B;
          end
        end
        ST_GOT_B: begin
          if (w_load_p) begin
            r_mode  <= sw[1:0];
            r_c_in  <= sw[2];
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Operands were stable for this whole cycle; capture the settled result.
          r_res_q     <= alu_result;
          r_cout_q    <= alu_c_out;
          r_res_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (w_load_p) begin
            r_res_valid <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
            r_a         <= r_res_q;
`else
            r_a         <= sw;
`endif
            r_state     <= ST_GOT_A;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign mode      = r_mode;
  assign c_in      = r_c_in;
  assign res_q     = r_res_q;
  assign cout_q    = r_cout_q;
  assign res_valid = r_res_valid;
  assign state_o   = r_state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed testbench for alu_operand_sequencer with a behavioural ALU in loop.
module tb_alu_operand_sequencer;

  logic       clk;
  logic       rst_n;
  logic [2:0] sw;
  logic       btn_load;
  logic       btn_clear;
  logic [2:0] alu_result;
  logic       alu_c_out;
  logic [2:0] a;
  logic [2:0] b;
  logic [1:0] mode;
  logic       c_in;
  logic [2:0] res_q;
  logic       cout_q;
  logic       res_valid;
  logic [2:0] state_o;

  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned exec_cycles;
  int unsigned exec_snap;

  alu_operand_sequencer #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .btn_load   (btn_load),
    .btn_clear  (btn_clear),
    .alu_result (alu_result),
    .alu_c_out  (alu_c_out),
    .a          (a),
    .b          (b),
    .mode       (mode),
    .c_in       (c_in),
    .res_q      (res_q),
    .cout_q     (cout_q),
    .res_valid  (res_valid),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: sub treats c_in as borrow-in, c_out high means no borrow.
  logic [3:0] w_sum;
  always_comb begin
    w_sum = '0;
    case (mode)
      2'b00:   w_sum = {1'b0, a} + {1'b0, b} + {3'b000, c_in};
      2'b01:   w_sum = {1'b0, a} + {1'b0, ~b} + {3'b000, ~c_in};
      2'b10:   w_sum = {1'b0, a ^ b};
      default: w_sum = {1'b0, a & b};
    endcase
  end
  assign alu_result = w_sum[2:0];
  assign alu_c_out  = w_sum[3];

  initial exec_cycles = 0;
  always @(negedge clk) begin
    if (state_o == 3'd3) exec_cycles = exec_cycles + 1;
  end

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic press(input logic ld, input logic cl, input logic [2:0] s, input int hold);
    sw        = s;
    btn_load  = ld;
    btn_clear = cl;
    wait_cycles(hold);
    btn_load  = 1'b0;
    btn_clear = 1'b0;
    wait_cycles(6);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_a"}, a, 0);
    chk({tag, "_b"}, b, 0);
    chk({tag, "_mode"}, mode, 0);
    chk({tag, "_cin"}, c_in, 0);
    chk({tag, "_res"}, res_q, 0);
    chk({tag, "_cout"}, cout_q, 0);
    chk({tag, "_valid"}, res_valid, 0);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    sw        = 3'd0;
    btn_load  = 1'b0;
    btn_clear = 1'b0;
    wait_cycles(3);
    chk_cleared("rst");
    rst_n = 1'b1;
    wait_cycles(6);
    chk("post_rst_state", state_o, 0);

    // Add overflow 7 + 1 + 0
    press(1'b1, 1'b0, 3'd7, 3);
    chk("add_ga_state", state_o, 1);
    chk("add_a", a, 7);
    press(1'b1, 1'b0, 3'd1, 3);
    chk("add_gb_state", state_o, 2);
    chk("add_b", b, 1);
    exec_snap = exec_cycles;
    press(1'b1, 1'b0, 3'b000, 3);
    chk("add_exec_len", exec_cycles - exec_snap, 1);
    chk("add_done_state", state_o, 4);
    chk("add_mode", mode, 0);
    chk("add_res", res_q, 0);
    chk("add_cout", cout_q, 1);
    chk("add_valid", res_valid, 1);

    press(1'b0, 1'b1, 3'd0, 3);
    chk_cleared("clr1");

    // Subtract 5 - 3
    press(1'b1, 1'b0, 3'd5, 3);
    press(1'b1, 1'b0, 3'd3, 3);
    press(1'b1, 1'b0, 3'b001, 3);
    chk("sub_mode", mode, 1);
    chk("sub_res", res_q, 2);
    chk("sub_cout", cout_q, 1);
    press(1'b0, 1'b1, 3'd0, 3);

    // Xor 6 ^ 3
    press(1'b1, 1'b0, 3'd6, 3);
    press(1'b1, 1'b0, 3'd3, 3);
    press(1'b1, 1'b0, 3'b010, 3);
    chk("xor_res", res_q, 5);
    chk("xor_cout", cout_q, 0);
    press(1'b0, 1'b1, 3'd0, 3);

    // 3 + 2, then a new operation started from DONE
    press(1'b1, 1'b0, 3'd3, 3);
    press(1'b1, 1'b0, 3'd2, 3);
    press(1'b1, 1'b0, 3'b000, 3);
    chk("ch_first_res", res_q, 5);
    press(1'b1, 1'b0, 3'd4, 3);
    chk("ch_ga_state", state_o, 1);
    chk("ch_valid_drop", res_valid, 0);
    chk("ch_res_hold", res_q, 5);
`ifdef ALU_SEQ_CHAIN_EN
    chk("ch_a", a, 5);
`else
    chk("ch_a", a, 4);
`endif
    press(1'b1, 1'b0, 3'd1, 3);
    press(1'b1, 1'b0, 3'b000, 3);
`ifdef ALU_SEQ_CHAIN_EN
    chk("ch_res", res_q, 6);
`else
    chk("ch_res", res_q, 5);
`endif
    chk("ch_valid", res_valid, 1);
    press(1'b0, 1'b1, 3'd0, 3);

    // Held load for 50 cycles yields exactly one step
    press(1'b1, 1'b0, 3'd6, 50);
    chk("hold_state", state_o, 1);
    chk("hold_a", a, 6);

    // Clear coincident with load in GOT_B
    press(1'b1, 1'b0, 3'd2, 3);
    chk("co_gb_state", state_o, 2);
    press(1'b1, 1'b1, 3'b111, 3);
    chk_cleared("co");

    // Reset asserted during EXEC
    press(1'b1, 1'b0, 3'd1, 3);
    press(1'b1, 1'b0, 3'd1, 3);
    sw       = 3'd0;
    btn_load = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state_o == 3'd3) break;
    end
    chk("rx_reach_exec", state_o, 3);
    rst_n = 1'b0;
    #1;
    chk("rx_state_now", state_o, 0);
    chk("rx_a_now", a, 0);
    btn_load = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(8);
    chk("rx_state", state_o, 0);
    chk("rx_valid", res_valid, 0);
    chk("rx_res", res_q, 0);

    // Button held through reset release must not pulse
    btn_load = 1'b1;
    sw       = 3'd3;
    wait_cycles(4);
    rst_n = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(12);
    chk("rh_held_state", state_o, 0);
    btn_load = 1'b0;
    wait_cycles(6);
    chk("rh_rel_state", state_o, 0);
    press(1'b1, 1'b0, 3'd3, 3);
    chk("rh_repress_state", state_o, 1);
    chk("rh_repress_a", a, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
